wearable_actuator_driver: RTL and testbench

//  Consumer end of the fsm_wearable actuator command interface. Takes the 6-bit actuator

---
 rtl/wearable_pkg.sv | 22 ++
 rtl/wearable_tick_gen.sv | 24 ++
 rtl/wearable_actuator_driver.sv | 146 ++++++++++++++
 tb/tb_wearable_actuator_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wearable_pkg.sv
// Shared constants for the wearable actuator driver: state codes, actuator bit map, FSM encoding.
package wearable_pkg;

  localparam logic [1:0] SC_IDLE     = 2'b00;
  localparam logic [1:0] SC_LIGHT    = 2'b01;
  localparam logic [1:0] SC_SEVERE   = 2'b10;
  localparam logic [1:0] SC_ACTIVITY = 2'b11;

  localparam int ACT_W         = 6;
  localparam int ACT_BUZZER    = 0;
  localparam int ACT_VIB       = 1;
  localparam int ACT_STEADY_LO = 2;
  localparam int ACT_STEADY_HI = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ON     = 2'd1,
    S_OFF    = 2'd2,
    S_SNOOZE = 2'd3
  } drv_state_e;

endpackage

// File: rtl/wearable_tick_gen.sv
// Timing-tick divider: tick_o pulses for one cycle every TICK_DIV cycles; clr_i restarts the count.
module wearable_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] div_q;

  assign tick_o = (div_q == DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i || tick_o) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/wearable_actuator_driver.sv
// Drives actuator pins from fsm_wearable commands: steady bits registered, buzzer/vibration burst-timed.
// Optional acknowledge/snooze is enabled by defining WEARABLE_SNOOZE_EN.
module wearable_actuator_driver
  import wearable_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int ON_TICKS     = 100,
  parameter int OFF_TICKS    = 400,
  parameter int BURSTS       = 3,
  parameter int SNOOZE_TICKS = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACT_W-1:0] actuator_cmd,
  input  logic [1:0]       state_code,
  input  logic             ack_btn,
  output logic [ACT_W-1:0] act_drive,
  output logic             alert_active,
  output logic             snoozed,
  output logic             pattern_done
);
  localparam int PH_A   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PH_MAX = (PH_A > SNOOZE_TICKS) ? PH_A : SNOOZE_TICKS;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BW     = $clog2(BURSTS + 1);

  logic [ACT_W-1:0] cmd_q;
  logic [1:0]       sc_q;
  logic             chg_q;
  drv_state_e       state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d, lim_m1;
  logic [BW-1:0]    burst_q, burst_d;
  logic             done_q, done_d;
  logic [1:0]       pulse_d;
  logic             div_clr, tick, ack_evt, restart, chg;

  wearable_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  assign chg = ({actuator_cmd, state_code} != {cmd_q, sc_q});

`ifdef WEARABLE_SNOOZE_EN
  logic ack_q, ack_rise_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      ack_rise_q <= 1'b0;
    end else begin
      ack_q      <= ack_btn;
      ack_rise_q <= ack_btn & ~ack_q;
    end
  end
  assign ack_evt = ack_rise_q;
  assign snoozed = (state_q == S_SNOOZE);
`else
  logic unused_ack;
  assign unused_ack = ack_btn;
  assign ack_evt    = 1'b0;
  assign snoozed    = 1'b0;
`endif

  // While snoozed only a change into SEVERE is allowed to break the silence.
  assign restart = chg_q && ((state_q != S_SNOOZE) || (sc_q == SC_SEVERE));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    burst_d = burst_q;
    done_d  = done_q;
    div_clr = 1'b0;
    case (state_q)
      S_ON:    lim_m1 = PW'(ON_TICKS - 1);
      S_OFF:   lim_m1 = PW'(OFF_TICKS - 1);
      default: lim_m1 = PW'(SNOOZE_TICKS - 1);
    endcase

    if (restart) begin
      state_d = (cmd_q[1:0] != 2'b00) ? S_ON : S_IDLE;
      phase_d = '0;
      burst_d = '0;
      done_d  = 1'b0;
      div_clr = 1'b1;
    end else if (ack_evt && (state_q == S_ON || state_q == S_OFF)) begin
      // Divider is realigned too so the silence lasts a whole number of ticks.
      state_d = S_SNOOZE;
      phase_d = '0;
      div_clr = 1'b1;
    end else if (tick && state_q != S_IDLE) begin
      if (phase_q == lim_m1) begin
        phase_d = '0;
        case (state_q)
          S_ON: begin
            state_d = S_OFF;
            if (burst_q < BW'(BURSTS)) burst_d = burst_q + BW'(1);
          end
          S_OFF: begin
            if (sc_q == SC_SEVERE || burst_q < BW'(BURSTS)) begin
              state_d = S_ON;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
          default: begin
            state_d = (cmd_q[1:0] != 2'b00) ? S_ON : S_IDLE;
            burst_d = '0;
          end
        endcase
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end

    pulse_d = (state_d == S_ON) ? cmd_q[ACT_VIB:ACT_BUZZER] : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= '0;
      sc_q      <= SC_IDLE;
      chg_q     <= 1'b0;
      state_q   <= S_IDLE;
      phase_q   <= '0;
      burst_q   <= '0;
      done_q    <= 1'b0;
      act_drive <= '0;
    end else begin
      cmd_q     <= actuator_cmd;
      sc_q      <= state_code;
      chg_q     <= chg;
      state_q   <= state_d;
      phase_q   <= phase_d;
      burst_q   <= burst_d;
      done_q    <= done_d;
      act_drive <= {cmd_q[ACT_STEADY_HI:ACT_STEADY_LO], pulse_d};
    end
  end

  assign alert_active = (state_q == S_ON) || (state_q == S_OFF);
  assign pattern_done = done_q;

endmodule

// File: tb/tb_wearable_actuator_driver.sv
// Scoreboard bench: each scenario queues the expected per-cycle outputs, then pops and compares them.
module tb_wearable_actuator_driver;
  import wearable_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] actuator_cmd;
  logic [1:0] state_code;
  logic       ack_btn;
  logic [5:0] act_drive;
  logic       alert_active, snoozed, pattern_done;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];

  // Expected sample = {act_drive, alert_active, snoozed, pattern_done}
  localparam logic [8:0] ZERO    = 9'b000000_000;
  localparam logic [8:0] SEV_ON  = 9'b111111_100;
  localparam logic [8:0] SEV_OFF = 9'b111100_100;

  always #5 clk = ~clk;

  wearable_actuator_driver #(
    .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(3), .BURSTS(2), .SNOOZE_TICKS(5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .actuator_cmd (actuator_cmd),
    .state_code   (state_code),
    .ack_btn      (ack_btn),
    .act_drive    (act_drive),
    .alert_active (alert_active),
    .snoozed      (snoozed),
    .pattern_done (pattern_done)
  );

  task automatic push(input int n, input logic [8:0] v);
    repeat (n) sb.push_back(v);
  endtask

  task automatic test_reset();
    logic [8:0] exp, obs;
    int n;
    sb.delete();
    push(7, ZERO);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {act_drive, alert_active, snoozed, pattern_done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset[%0d] got=%b expected=%b", i, obs, exp);
      end
      if (i == 2) begin rst = 1'b0; actuator_cmd = 6'b000000; state_code = SC_IDLE; end
    end
    $display("test_reset: %0d samples", n);
  endtask

  task automatic test_steady();
    logic [8:0] exp, obs;
    int n;
    sb.delete();
    actuator_cmd = 6'b101100; state_code = SC_LIGHT;
    push(1, ZERO);
    push(10, 9'b101100_000);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {act_drive, alert_active, snoozed, pattern_done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL steady[%0d] got=%b expected=%b", i, obs, exp);
      end
    end
    $display("test_steady: %0d samples", n);
  endtask

  task automatic test_burst();
    logic [8:0] exp, obs;
    int n;
    sb.delete();
    actuator_cmd = 6'b101110; state_code = SC_ACTIVITY;
    push(1, 9'b101100_000);
    repeat (2) begin
      push(8, 9'b101110_100);
      push(12, 9'b101100_100);
    end
    push(6, 9'b101100_001);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {act_drive, alert_active, snoozed, pattern_done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL burst[%0d] got=%b expected=%b", i, obs, exp);
      end
    end
    $display("test_burst: %0d samples", n);
  endtask

  task automatic test_severe();
    logic [8:0] exp, obs;
    int n;
    sb.delete();
    actuator_cmd = 6'b111111; state_code = SC_SEVERE;
    push(1, 9'b101100_001);
    repeat (6) begin
      push(8, SEV_ON);
      push(12, SEV_OFF);
    end
    push(8, SEV_ON);
    push(5, SEV_OFF);
    push(1, SEV_OFF);
    push(5, ZERO);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {act_drive, alert_active, snoozed, pattern_done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL severe[%0d] got=%b expected=%b", i, obs, exp);
      end
      if (i == 133) begin actuator_cmd = 6'b000000; state_code = SC_IDLE; end
    end
    $display("test_severe: %0d samples", n);
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp, obs;
    int n;
    sb.delete();
    actuator_cmd = 6'b111111; state_code = SC_SEVERE;
    push(1, ZERO);
    push(4, SEV_ON);
    push(3, ZERO);
    push(8, SEV_ON);
    push(2, SEV_OFF);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {act_drive, alert_active, snoozed, pattern_done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_mid[%0d] got=%b expected=%b", i, obs, exp);
      end
      if (i == 4) rst = 1'b1;
      if (i == 6) rst = 1'b0;
    end
    $display("test_reset_mid: %0d samples", n);
  endtask

`ifdef WEARABLE_SNOOZE_EN
  task automatic test_snooze();
    logic [8:0] exp, obs;
    int n;
    sb.delete();
    rst = 1'b1; actuator_cmd = 6'b111111; state_code = SC_SEVERE; ack_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(1, ZERO);
    push(4, SEV_ON);
    push(20, 9'b111100_010);
    push(3, SEV_ON);
    push(4, 9'b111100_010);
    push(4, 9'b101100_010);
    push(8, SEV_ON);
    push(2, SEV_OFF);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {act_drive, alert_active, snoozed, pattern_done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL snooze[%0d] got=%b expected=%b", i, obs, exp);
      end
      if (i == 3 || i == 26) ack_btn = 1'b1;
      if (i == 4 || i == 27) ack_btn = 1'b0;
      if (i == 30) begin actuator_cmd = 6'b101110; state_code = SC_LIGHT; end
      if (i == 34) begin actuator_cmd = 6'b111111; state_code = SC_SEVERE; end
    end
    $display("test_snooze: %0d samples", n);
  endtask
`else
  task automatic test_ack_ignored();
    logic [8:0] exp, obs;
    int n;
    sb.delete();
    rst = 1'b1; actuator_cmd = 6'b111111; state_code = SC_SEVERE; ack_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(1, ZERO);
    push(8, SEV_ON);
    push(12, SEV_OFF);
    push(2, SEV_ON);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {act_drive, alert_active, snoozed, pattern_done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL ack_ignored[%0d] got=%b expected=%b", i, obs, exp);
      end
      if (i == 3) ack_btn = 1'b1;
      if (i == 4) ack_btn = 1'b0;
    end
    $display("test_ack_ignored: %0d samples", n);
  endtask
`endif

  initial begin
    rst = 1'b1;
    actuator_cmd = 6'b111111;
    state_code = SC_IDLE;
    ack_btn = 1'b0;
    test_reset();
    test_steady();
    test_burst();
    test_severe();
    test_reset_mid();
`ifdef WEARABLE_SNOOZE_EN
    test_snooze();
`else
    test_ack_ignored();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
